// File: rtl/batcharger_pkg.sv
// Shared types and defaults for the multi-channel Li-ion charge controller.
// Optional safety timer is enabled by defining BATCHARGER_TIMEOUT_EN.
package batcharger_pkg;

    typedef enum logic [2:0] {
        ST_OFF  = 3'd0,
        ST_TC   = 3'd1,
        ST_CC   = 3'd2,
        ST_CV   = 3'd3,
        ST_DONE = 3'd4
    } state_t;

    // Mode flags packed as {done, cv, cc, tc}
    localparam logic [3:0] MODE_NONE = 4'b0000;
    localparam logic [3:0] MODE_TC   = 4'b0001;
    localparam logic [3:0] MODE_CC   = 4'b0010;
    localparam logic [3:0] MODE_CV   = 4'b0100;
    localparam logic [3:0] MODE_DONE = 4'b1000;

    localparam int DEB_DEF      = 4;
    localparam int TOUT_W_DEF   = 16;
    localparam int TOUT_MAX_DEF = 40000;

    function automatic logic [3:0] mode_of(state_t s);
        case (s)
            ST_TC:   return MODE_TC;
            ST_CC:   return MODE_CC;
            ST_CV:   return MODE_CV;
            ST_DONE: return MODE_DONE;
            default: return MODE_NONE;
        endcase
    endfunction

endpackage

// File: rtl/batcharger_ctrl_nch_if.sv
// Bus between the charger controller and the analog front end / sampler.
// master drives ADC codes, enables and thresholds; slave is the controller.
interface batcharger_ctrl_nch_if #(
    parameter int NCH   = 2,
    parameter int ADC_W = 10
);
    logic [NCH-1:0]       en;
    logic                 smp_vld;
    logic [NCH*ADC_W-1:0] vbat;
    logic [NCH*ADC_W-1:0] ibat;
    logic [NCH*ADC_W-1:0] vtemp;
    logic [ADC_W-1:0]     vcutoff;
    logic [ADC_W-1:0]     vpreset;
    logic [ADC_W-1:0]     vrech;
    logic [ADC_W-1:0]     itc;
    logic [ADC_W-1:0]     icc;
    logic [ADC_W-1:0]     iend;
    logic [ADC_W-1:0]     tmin;
    logic [ADC_W-1:0]     tmax;
    logic [NCH-1:0]       tc;
    logic [NCH-1:0]       cc;
    logic [NCH-1:0]       cv;
    logic [NCH-1:0]       done;
    logic [NCH-1:0]       fault;
    logic [NCH*ADC_W-1:0] iset;
    logic [NCH*ADC_W-1:0] vset;

    modport master (
        output en, smp_vld, vbat, ibat, vtemp,
        output vcutoff, vpreset, vrech, itc, icc, iend, tmin, tmax,
        input  tc, cc, cv, done, fault, iset, vset
    );

    modport slave (
        input  en, smp_vld, vbat, ibat, vtemp,
        input  vcutoff, vpreset, vrech, itc, icc, iend, tmin, tmax,
        output tc, cc, cv, done, fault, iset, vset
    );
endinterface

// File: rtl/batcharger_ch_fsm.sv
// One charge channel: TC/CC/CV/DONE sequencer with per-condition debounce,
// temperature window shutdown and registered setpoint mux.
// Define BATCHARGER_TIMEOUT_EN to add the saturating safety timer.
//
//  state   | meaning
//  OFF     | disabled or faulted, classifying vbat to pick a start state
//  TC      | trickle charge, iset=itc
//  CC      | constant current, iset=icc
//  CV      | constant voltage, waiting for ibat to fall to iend
//  DONE    | charged, setpoints off, watching for recharge threshold
module batcharger_ch_fsm
    import batcharger_pkg::*;
#(
    parameter int ADC_W = 10,
    parameter int DEB   = DEB_DEF
`ifdef BATCHARGER_TIMEOUT_EN
    ,
    parameter int TOUT_W   = TOUT_W_DEF,
    parameter int TOUT_MAX = TOUT_MAX_DEF
`endif
) (
    input  logic             clk_i,
    input  logic             rst_n_i,
    input  logic             en_i,
    input  logic             smp_vld_i,
    input  logic [ADC_W-1:0] vbat_i,
    input  logic [ADC_W-1:0] ibat_i,
    input  logic [ADC_W-1:0] vtemp_i,
    input  logic [ADC_W-1:0] vcutoff_i,
    input  logic [ADC_W-1:0] vpreset_i,
    input  logic [ADC_W-1:0] vrech_i,
    input  logic [ADC_W-1:0] itc_i,
    input  logic [ADC_W-1:0] icc_i,
    input  logic [ADC_W-1:0] iend_i,
    input  logic [ADC_W-1:0] tmin_i,
    input  logic [ADC_W-1:0] tmax_i,
    output logic             tc_o,
    output logic             cc_o,
    output logic             cv_o,
    output logic             done_o,
    output logic             fault_o,
    output logic [ADC_W-1:0] iset_o,
    output logic [ADC_W-1:0] vset_o
);
    localparam int             CW    = $clog2(DEB + 1);
    localparam logic [CW-1:0]  DEB_C = CW'(DEB);

    state_t              state_q, state_d;
    logic [2:0][CW-1:0]  cnt_q, cnt_d;
    logic                fault_q, fault_d;
    logic [3:0]          mode_q, mode_d;
    logic [ADC_W-1:0]    iset_q, iset_d, vset_q, vset_d;
    logic                temp_ok;
    logic [2:0]          cond;
    state_t              tgt [3];

`ifdef BATCHARGER_TIMEOUT_EN
    localparam logic [TOUT_W-1:0] TOUT_C = TOUT_W'(TOUT_MAX);
    logic [TOUT_W-1:0] tout_q, tout_d, tout_inc;
    logic              tfault_q, tfault_d, tout_hit;
`endif

    // State, run counters and registered outputs
    always_ff @(posedge clk_i or negedge rst_n_i) begin
        if (!rst_n_i) begin
            state_q <= ST_OFF;
            cnt_q   <= '0;
            fault_q <= 1'b0;
            mode_q  <= MODE_NONE;
            iset_q  <= '0;
            vset_q  <= '0;
`ifdef BATCHARGER_TIMEOUT_EN
            tout_q   <= '0;
            tfault_q <= 1'b0;
`endif
        end else begin
            state_q <= state_d;
            cnt_q   <= cnt_d;
            fault_q <= fault_d;
            mode_q  <= mode_d;
            iset_q  <= iset_d;
            vset_q  <= vset_d;
`ifdef BATCHARGER_TIMEOUT_EN
            tout_q   <= tout_d;
            tfault_q <= tfault_d;
`endif
        end
    end

    // Next state: enable, then temperature/timeout shutdown, then debounced moves
    always_comb begin
        state_d = state_q;
        cnt_d   = cnt_q;
        fault_d = fault_q;
        temp_ok = (vtemp_i >= tmin_i) && (vtemp_i <= tmax_i);
        cond    = '0;
        tgt[0]  = ST_OFF;
        tgt[1]  = ST_OFF;
        tgt[2]  = ST_OFF;

        case (state_q)
            ST_OFF: begin
                cond[0] = vbat_i < vcutoff_i;
                cond[1] = (vbat_i >= vcutoff_i) && (vbat_i < vpreset_i);
                cond[2] = vbat_i >= vpreset_i;
                tgt[0]  = ST_TC;
                tgt[1]  = ST_CC;
                tgt[2]  = ST_DONE;
            end
            ST_TC: begin
                cond[0] = vbat_i >= vcutoff_i;
                tgt[0]  = ST_CC;
            end
            ST_CC: begin
                cond[0] = vbat_i >= vpreset_i;
                tgt[0]  = ST_CV;
            end
            ST_CV: begin
                cond[0] = ibat_i <= iend_i;
                tgt[0]  = ST_DONE;
            end
            ST_DONE: begin
                cond[0] = vbat_i < vrech_i;
                tgt[0]  = ST_CC;
            end
            default: ;
        endcase

`ifdef BATCHARGER_TIMEOUT_EN
        tout_d   = tout_q;
        tfault_d = tfault_q;
        tout_hit = 1'b0;
        tout_inc = (tout_q == '1) ? tout_q : tout_q + 1'b1;
        if (smp_vld_i && (state_q inside {ST_TC, ST_CC, ST_CV})) begin
            tout_d   = tout_inc;
            tout_hit = tout_inc >= TOUT_C;
        end
        // A timed-out channel may not restart until it is disabled
        if (tfault_q) cond = '0;
`endif

        if (!en_i) begin
            state_d = ST_OFF;
            cnt_d   = '0;
            fault_d = 1'b0;
        end else if (smp_vld_i) begin
            if (!temp_ok) begin
                state_d = ST_OFF;
                cnt_d   = '0;
                fault_d = 1'b1;
`ifdef BATCHARGER_TIMEOUT_EN
            end else if (tout_hit) begin
                state_d  = ST_OFF;
                cnt_d    = '0;
                fault_d  = 1'b1;
                tfault_d = 1'b1;
`endif
            end else begin
                for (int i = 0; i < 3; i++) begin
                    cnt_d[i] = cond[i] ? cnt_q[i] + 1'b1 : '0;
                    if (cnt_d[i] == DEB_C) state_d = tgt[i];
                end
                if (state_d != state_q) begin
                    cnt_d   = '0;
                    fault_d = 1'b0;
                end
            end
        end

`ifdef BATCHARGER_TIMEOUT_EN
        if (!en_i) tfault_d = 1'b0;
        if ((state_d == ST_OFF) || ((state_q == ST_DONE) && (state_d == ST_CC)))
            tout_d = '0;
`endif
    end

    // Setpoints and mode flags follow the state being entered
    always_comb begin
        mode_d = mode_of(state_d);
        iset_d = '0;
        vset_d = '0;
        case (state_d)
            ST_TC: begin
                iset_d = itc_i;
                vset_d = vpreset_i;
            end
            ST_CC, ST_CV: begin
                iset_d = icc_i;
                vset_d = vpreset_i;
            end
            default: ;
        endcase
    end

    assign tc_o    = mode_q[0];
    assign cc_o    = mode_q[1];
    assign cv_o    = mode_q[2];
    assign done_o  = mode_q[3];
    assign fault_o = fault_q;
    assign iset_o  = iset_q;
    assign vset_o  = vset_q;

endmodule

// File: rtl/batcharger_ctrl_nch.sv
// NCH independent charge channels sharing thresholds.
// Define BATCHARGER_TIMEOUT_EN to add the per-channel safety timer.
module batcharger_ctrl_nch
    import batcharger_pkg::*;
#(
    parameter int NCH   = 2,
    parameter int ADC_W = 10,
    parameter int DEB   = DEB_DEF
`ifdef BATCHARGER_TIMEOUT_EN
    ,
    parameter int TOUT_W   = TOUT_W_DEF,
    parameter int TOUT_MAX = TOUT_MAX_DEF
`endif
) (
    input logic                   clk,
    input logic                   rstz,
    batcharger_ctrl_nch_if.slave  bus
);
    wire [NCH-1:0]       tc_w, cc_w, cv_w, done_w, fault_w;
    wire [NCH*ADC_W-1:0] iset_w, vset_w;

    for (genvar k = 0; k < NCH; k++) begin : g_ch
        batcharger_ch_fsm #(
            .ADC_W(ADC_W),
            .DEB  (DEB)
`ifdef BATCHARGER_TIMEOUT_EN
            ,
            .TOUT_W  (TOUT_W),
            .TOUT_MAX(TOUT_MAX)
`endif
        ) u_ch (
            .clk_i    (clk),
            .rst_n_i  (rstz),
            .en_i     (bus.en[k]),
            .smp_vld_i(bus.smp_vld),
            .vbat_i   (bus.vbat[k*ADC_W +: ADC_W]),
            .ibat_i   (bus.ibat[k*ADC_W +: ADC_W]),
            .vtemp_i  (bus.vtemp[k*ADC_W +: ADC_W]),
            .vcutoff_i(bus.vcutoff),
            .vpreset_i(bus.vpreset),
            .vrech_i  (bus.vrech),
            .itc_i    (bus.itc),
            .icc_i    (bus.icc),
            .iend_i   (bus.iend),
            .tmin_i   (bus.tmin),
            .tmax_i   (bus.tmax),
            .tc_o     (tc_w[k]),
            .cc_o     (cc_w[k]),
            .cv_o     (cv_w[k]),
            .done_o   (done_w[k]),
            .fault_o  (fault_w[k]),
            .iset_o   (iset_w[k*ADC_W +: ADC_W]),
            .vset_o   (vset_w[k*ADC_W +: ADC_W])
        );
    end

    assign bus.tc    = tc_w;
    assign bus.cc    = cc_w;
    assign bus.cv    = cv_w;
    assign bus.done  = done_w;
    assign bus.fault = fault_w;
    assign bus.iset  = iset_w;
    assign bus.vset  = vset_w;

endmodule
